// File: rtl/mse_frame_packer_if.sv
// Byte-frame packer bus: MSE capture inputs, UART byte interface, status.
// Latency: n/a (signal bundle only).
// Backpressure: tx_busy from the transmitter stalls the packer between bytes.
// Ports: mse_data/mse_valid (capture), tx_busy/com_txvalid/com_txdata (UART),
//        busy/frame_done/overrun (status).
interface mse_frame_packer_if #(
    parameter int NUM_DSP = 2
);
    logic [NUM_DSP-1:0][63:0] mse_data;
    logic [NUM_DSP-1:0]       mse_valid;
    logic                     tx_busy;
    logic                     com_txvalid;
    logic [7:0]               com_txdata;
    logic                     busy;
    logic                     frame_done;
    logic [NUM_DSP-1:0]       overrun;

    // master: collectors + transmitter side (drives captures and tx_busy)
    modport master (
        output mse_data, mse_valid, tx_busy,
        input  com_txvalid, com_txdata, busy, frame_done, overrun
    );

    // slave: the packer itself
    modport slave (
        input  mse_data, mse_valid, tx_busy,
        output com_txvalid, com_txdata, busy, frame_done, overrun
    );
endinterface

// File: rtl/mse_frame_packer.sv
// Captures per-channel 64-bit MSE results and serialises them as byte frames
// (HDR, channel, 8 data bytes MSB first [, XOR checksum]) to a UART transmitter.
// Latency: capture at t -> LOAD at t+1 -> first byte at t+2 when tx_busy=0.
// Backpressure: each byte waits for tx_busy low, then a full high/low cycle.
// Ports: clk, rstn (synchronous, active-low), bus (mse_frame_packer_if.slave).
// Build option: define MSE_PACK_CHECKSUM_EN to append the checksum byte (11-byte frame).
module mse_frame_packer #(
    parameter int          NUM_DSP = 2,
    parameter logic [7:0]  HDR     = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rstn,
    mse_frame_packer_if.slave    bus
);

`ifdef MSE_PACK_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd10;
`else
    localparam logic [3:0] LAST_IDX = 4'd9;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EMIT,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [63:0]         r_cap [NUM_DSP];
    logic [NUM_DSP-1:0]  r_pend;
    logic [NUM_DSP-1:0]  r_ovr;
    logic [63:0]         r_shift;
    logic [2:0]          r_chan;
    logic [3:0]          r_cnt;
`ifdef MSE_PACK_CHECKSUM_EN
    logic [7:0]          r_csum;
`endif

    logic [2:0]          w_sel;
    logic [63:0]         w_sel_dat;
    logic [7:0]          w_byte;
    logic                w_load;
    logic                w_txvalid;
    logic [7:0]          w_txdata;
    logic                w_done;
    logic                w_data_byte;

    // Lowest-index pending channel; descending scan lets low indices win.
    always_comb begin
        w_sel     = '0;
        w_sel_dat = '0;
        for (int i = NUM_DSP - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_sel     = 3'(i);
                w_sel_dat = r_cap[i];
            end
        end
    end

    // Bytes 2..9 come from the top of the shift register.
    assign w_data_byte = (r_cnt >= 4'd2) && (r_cnt <= 4'd9);

    always_comb begin
        w_byte = r_shift[63:56];
        if (r_cnt == 4'd0) begin
            w_byte = HDR;
        end else if (r_cnt == 4'd1) begin
            w_byte = {5'd0, r_chan};
        end
`ifdef MSE_PACK_CHECKSUM_EN
        else if (r_cnt == 4'd10) begin
            w_byte = r_csum;
        end
`endif
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_txvalid = 1'b0;
        w_txdata  = 8'd0;
        w_done    = 1'b0;
        case (r_state)
            // Look at the strobes too so a capture reaches LOAD on the next cycle.
            S_IDLE:    if ((|r_pend) || (|bus.mse_valid)) w_next = S_LOAD;
            S_LOAD: begin
                w_load = 1'b1;
                w_next = S_EMIT;
            end
            S_EMIT: begin
                if (!bus.tx_busy) begin
                    w_txvalid = 1'b1;
                    w_txdata  = w_byte;
                    w_next    = S_WAIT_HI;
                end
            end
            S_WAIT_HI: if (bus.tx_busy) w_next = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    if (r_cnt == LAST_IDX) begin
                        w_done = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_EMIT;
                    end
                end
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pend  <= '0;
            r_ovr   <= '0;
            r_shift <= '0;
            r_chan  <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < NUM_DSP; i++) r_cap[i] <= '0;
`ifdef MSE_PACK_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            if (w_load) begin
                r_shift <= w_sel_dat;
                r_chan  <= w_sel;
                r_cnt   <= 4'd0;
`ifdef MSE_PACK_CHECKSUM_EN
                r_csum  <= 8'd0;
`endif
            end
            if (w_txvalid && w_data_byte) begin
                r_shift <= {r_shift[55:0], 8'd0};
`ifdef MSE_PACK_CHECKSUM_EN
                r_csum  <= r_csum ^ r_shift[63:56];
`endif
            end
            if ((r_state == S_WAIT_LO) && !bus.tx_busy && (r_cnt != LAST_IDX)) begin
                r_cnt <= r_cnt + 4'd1;
            end
            // A capture on the channel being loaded keeps it pending with the
            // new value and is not an overrun: the old value is the one sent.
            for (int i = 0; i < NUM_DSP; i++) begin
                if (bus.mse_valid[i]) begin
                    r_cap[i]  <= bus.mse_data[i];
                    r_pend[i] <= 1'b1;
                    if (r_pend[i] && !(w_load && (w_sel == 3'(i)))) r_ovr[i] <= 1'b1;
                end else if (w_load && (w_sel == 3'(i))) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.com_txvalid = w_txvalid;
    assign bus.com_txdata  = w_txdata;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.frame_done  = w_done;
    assign bus.overrun     = r_ovr;

endmodule
